// File: rtl/interrupt_sequencer_pkg.sv
// Shared encodings for the interrupt sequencer: FSM states, vector codes,
// source bit positions and the priority/one-hot helpers.
package interrupt_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_PRESENT = 2'b01;
  localparam logic [1:0] ST_CLEAR   = 2'b10;
  localparam logic [1:0] ST_HOLDOFF = 2'b11;

  localparam int unsigned SRC_REC  = 0;
  localparam int unsigned SRC_TRA  = 1;
  localparam int unsigned SRC_STAT = 2;
  localparam int unsigned NUM_SRC  = 3;

  typedef logic [1:0]         irq_vec_t;
  typedef logic [NUM_SRC-1:0] src_mask_t;

  localparam irq_vec_t VEC_REC  = 2'b00;
  localparam irq_vec_t VEC_TRA  = 2'b01;
  localparam irq_vec_t VEC_STAT = 2'b10;
  localparam irq_vec_t VEC_NONE = 2'b11;

  // Fixed priority: rec beats tra beats stat.
  function automatic irq_vec_t prio_vec(input src_mask_t pend);
    if (pend[SRC_REC])       return VEC_REC;
    else if (pend[SRC_TRA])  return VEC_TRA;
    else if (pend[SRC_STAT]) return VEC_STAT;
    return VEC_NONE;
  endfunction

  function automatic src_mask_t vec_mask(input irq_vec_t vec);
    case (vec)
      VEC_REC:  return 3'b001;
      VEC_TRA:  return 3'b010;
      VEC_STAT: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Bus between the interrupt unit / CPU (master) and the sequencer (slave).
interface interrupt_sequencer_if;
  logic       set_strobe;
  logic       set_rec;
  logic       set_tra;
  logic       set_stat;
  logic       ien_wr;
  logic [2:0] ien_wdata;
  logic       ack;
  logic [2:0] ienable;
  logic [2:0] irqstd;
  logic       irq;
  logic [1:0] irq_vec;

  modport master (
    output set_strobe, set_rec, set_tra, set_stat, ien_wr, ien_wdata, ack,
    input  ienable, irqstd, irq, irq_vec
  );

  modport slave (
    input  set_strobe, set_rec, set_tra, set_stat, ien_wr, ien_wdata, ack,
    output ienable, irqstd, irq, irq_vec
  );
endinterface

// File: rtl/interrupt_sequencer_holdoff.sv
// irq_holdoff_timer: 4-bit down-counter with load; done while the count is zero.
module irq_holdoff_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       done_o
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (count_q != 4'd0)
      count_d = count_q - 4'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) count_q <= 4'd0;
    else        count_q <= count_d;
  end

  assign done_o = (count_q == 4'd0);

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: pending/enable registers and a present/ack FSM.
// Optional post-ack hold-off is built when IRQ_HOLDOFF_EN is defined.
module interrupt_sequencer
  import interrupt_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  interrupt_sequencer_if.slave  bus
);

  if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 15) begin : g_bad_holdoff
    $error("HOLDOFF_CYCLES must lie in 1..15");
  end

  logic [1:0] state_q, state_d;
  src_mask_t  ienable_q, ienable_d;
  src_mask_t  irqstd_q, irqstd_d;
  irq_vec_t   vec_q, vec_d;

  src_mask_t  wr_mask;
  src_mask_t  set_bits;
  src_mask_t  clr_bits;
  src_mask_t  visible;
  logic       cancel;

`ifdef IRQ_HOLDOFF_EN
  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_CYCLES - 1);
  logic hold_load;
  logic hold_done;

  irq_holdoff_timer u_holdoff (
    .clock      (clock),
    .reset      (reset),
    .load_i     (hold_load),
    .load_val_i (HOLD_LOAD),
    .done_o     (hold_done)
  );
`endif

  // An enable write masks pending bits on the same edge; a new set beats the
  // CLEAR-state clear of the same bit.
  always_comb begin
    wr_mask   = bus.ien_wr ? bus.ien_wdata : 3'b111;
    set_bits  = bus.set_strobe
              ? ({bus.set_stat, bus.set_tra, bus.set_rec} & ienable_q) : 3'b000;
    clr_bits  = (state_q == ST_CLEAR) ? vec_mask(vec_q) : 3'b000;
    irqstd_d  = ((irqstd_q & ~clr_bits) | set_bits) & wr_mask;
    ienable_d = bus.ien_wr ? bus.ien_wdata : ienable_q;
    visible   = irqstd_q & wr_mask;
    cancel    = bus.ien_wr && ((bus.ien_wdata & vec_mask(vec_q)) == 3'b000);
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
`ifdef IRQ_HOLDOFF_EN
    hold_load = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (visible != 3'b000) begin
          vec_d   = prio_vec(visible);
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (cancel)
          state_d = ST_IDLE;
        else if (bus.ack)
          state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
`ifdef IRQ_HOLDOFF_EN
        hold_load = 1'b1;
        state_d   = ST_HOLDOFF;
`else
        state_d   = ST_IDLE;
`endif
      end
`ifdef IRQ_HOLDOFF_EN
      ST_HOLDOFF: begin
        if (hold_done)
          state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ienable_q <= 3'b000;
      irqstd_q  <= 3'b000;
      vec_q     <= VEC_NONE;
    end else begin
      state_q   <= state_d;
      ienable_q <= ienable_d;
      irqstd_q  <= irqstd_d;
      vec_q     <= vec_d;
    end
  end

  assign bus.ienable = ienable_q;
  assign bus.irqstd  = irqstd_q;
  assign bus.irq     = (state_q == ST_PRESENT);
  assign bus.irq_vec = (state_q == ST_PRESENT) ? vec_q : VEC_NONE;

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 The block SHALL have parameter HOLDOFF_CYCLES, default 8, giving the number of hold-off cycles after each acknowledged interrupt (range 1..15).
REQ-002 The block SHALL have port clock, input, 1, the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous, active-low.
REQ-004 The block SHALL have port set_strobe, input, 1, an indication update pulse from the interrupt unit.
REQ-005 The block SHALL have ports set_rec, set_tra, set_stat, input, 1 each, the source flags qualified by set_strobe.
REQ-006 The block SHALL have port ien_wr, input, 1, the CPU write strobe for the enable register.
REQ-007 The block SHALL have port ien_wdata, input, 3, the enable write data: bit0 rec, bit1 tra, bit2 stat.
REQ-008 The block SHALL have port ack, input, 1, the CPU acknowledge of the presented vector.
REQ-009 The block SHALL have port ienable, output, 3, the current enable register.
REQ-010 The block SHALL have port irqstd, output, 3, the pending register, with the same bit order as ienable.
REQ-011 The block SHALL have port irq, output, 1, the interrupt request line.
REQ-012 The block SHALL have port irq_vec, output, 2, the presented source: 00 rec, 01 tra, 10 stat, 11 none.

Function
REQ-013 Pending bit x SHALL be set on the clock edge where set_strobe=1, the source-x flag=1 and ienable[x]=1; set flags without set_strobe SHALL be ignored.
REQ-014 A write with ien_wr=1 SHALL load ienable from ien_wdata, and SHALL clear every pending bit whose new enable bit is 0, on the same edge.
REQ-015 The state machine SHALL have states IDLE, PRESENT, CLEAR and HOLDOFF.
REQ-016 In IDLE, if any pending bit is 1, the block SHALL latch the highest-priority pending source (rec > tra > stat) into irq_vec and enter PRESENT on the next edge.
REQ-017 In PRESENT, irq SHALL be 1 and irq_vec SHALL be held stable until ack or cancellation.
REQ-018 In PRESENT with ack=1, the block SHALL enter CLEAR; ack outside PRESENT SHALL be ignored.
REQ-019 In PRESENT, if the latched pending bit is cleared by an enable write, the block SHALL return to IDLE without an ack, with irq=0 and irq_vec=11 on the next cycle.
REQ-020 In CLEAR, the block SHALL clear the latched pending bit, set irq=0 and irq_vec=11, then enter HOLDOFF (macro defined) or IDLE (macro undefined).
REQ-021 If, in CLEAR, a new set arrives for the same bit, the set SHALL win and the bit SHALL stay 1.
REQ-022 In IDLE, irq SHALL be 0 and irq_vec SHALL be 11.
REQ-023 Minimum latency SHALL be: set edge to irq=1 in 2 cycles; ack edge to the next irq=1 in 3 cycles without the macro, or 3+HOLDOFF_CYCLES cycles with it.
REQ-024 Illegal state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-025 With reset=0 at a clock edge, the block SHALL set state=IDLE, ienable=000, irqstd=000, irq=0, irq_vec=11 and the hold-off counter to 0, overriding all other inputs including mid-PRESENT.

Configuration
REQ-026 With IRQ_HOLDOFF_EN defined, HOLDOFF SHALL count HOLDOFF_CYCLES cycles with irq=0 before entering IDLE, while pending bits still set normally.
REQ-027 With IRQ_HOLDOFF_EN undefined, the HOLDOFF state and counter SHALL be absent and CLEAR SHALL go directly to IDLE.

Structure
REQ-028 Package interrupt_pkg SHALL hold the state encoding, vector constants (VEC_REC, VEC_TRA, VEC_STAT, VEC_NONE) and source bit indices.
REQ-029 The hold-off counter SHALL be sub-module irq_holdoff_timer (4-bit down-counter with load and done), instantiated only under IRQ_HOLDOFF_EN.

Verification
REQ-030 Scenario 1: ienable=111, then set_strobe with set_tra -> irqstd=010, irq=1 two cycles later, irq_vec=01.
REQ-031 Scenario 2: set rec and stat simultaneously -> irq_vec=00 first; after ack, irqstd=100 and irq_vec=10 presented next.
REQ-032 Scenario 3: in PRESENT with vec=10, write ien_wdata=011 -> irqstd[2]=0, irq=0 next cycle, no ack required.
REQ-033 Scenario 4: in CLEAR for rec, assert set_rec -> irqstd[0] remains 1 and rec is re-presented.
REQ-034 Scenario 5: with IRQ_HOLDOFF_EN and HOLDOFF_CYCLES=8, ack while tra is also pending -> irq low for exactly 10 cycles (1 CLEAR + 8 HOLDOFF + 1 IDLE latch), then irq_vec=01.
REQ-035 Scenario 6: reset=0 during PRESENT -> all outputs at reset values on the next edge, and ack after reset ignored.
